led_scanner: RTL and testbench
==============================

LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of LED outputs; legal range 2..32.
REQ-002 The block SHALL have parameter PRESCALE_BITS, default 18: prescaler counter width; legal range 2..24.
REQ-003 The block SHALL have parameter EYE_LEN, default 1: number of adjacent lit LEDs; legal range 1..WIDTH-1.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: 1 = prescaler runs; 0 = prescaler and pattern freeze.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 bounce, 01 rotate-left, 10 rotate-right, 11 hold.
REQ-008 The block SHALL have port speed, input, 3 bits: step-rate select, higher = faster.
REQ-009 The block SHALL have port restart, input, 1 bit: synchronous reload of the initial pattern.
REQ-010 The block SHALL have port leds, output, WIDTH bits: eye pattern.
REQ-011 The block SHALL have port position, output, $clog2(WIDTH) bits: index of the eye's base LED.
REQ-012 The block SHALL have port direction, output, 1 bit: 0 = left (toward MSB), 1 = right.
REQ-013 The block SHALL have port step, output, 1 bit: one-cycle pulse on every tick.
REQ-014 The block SHALL have port bounce, output, 1 bit: one-cycle pulse on every direction reversal.

Function
REQ-015 Prescaler cnt SHALL increment by 1 modulo 2^PRESCALE_BITS on each cycle with enable=1 and restart=0.
REQ-016 K SHALL equal max(1, PRESCALE_BITS-speed); a tick SHALL occur in the cycle where enable=1 and cnt[K-1:0] is all ones, i.e. every 2^K enabled cycles; a speed change SHALL take effect the next cycle.
REQ-017 leds bit i SHALL be 1 iff ((i-position) mod WIDTH) < EYE_LEN; leds, position and direction SHALL be registered.
REQ-018 Bounce, tick, direction=0: if position = WIDTH-EYE_LEN, direction SHALL become 1 with no move (one-tick dwell) and bounce SHALL pulse; else position SHALL increment.
REQ-019 Bounce, tick, direction=1: if position = 0, direction SHALL become 0 with no move and bounce SHALL pulse; else position SHALL decrement.
REQ-020 Bounce, tick, position > WIDTH-EYE_LEN (entered from a rotate mode): position SHALL load WIDTH-EYE_LEN, direction SHALL become 1, and bounce SHALL pulse.
REQ-021 Rotate-left, tick: position SHALL become (position+1) mod WIDTH, direction SHALL be 0, and bounce SHALL stay 0.
REQ-022 Rotate-right, tick: position SHALL become (position-1) mod WIDTH, direction SHALL be 1, and bounce SHALL stay 0.
REQ-023 Hold, tick: position and direction SHALL be unchanged while step still pulses.
REQ-024 step SHALL assert in the cycle after the tick, coincident with the updated leds; bounce SHALL assert in that same cycle.
REQ-025 restart=1 SHALL set position 0, direction 0 and cnt 0, and SHALL suppress that cycle's tick; restart SHALL take priority over enable and mode.
REQ-026 enable=0 SHALL hold cnt, leds, position and direction, and SHALL force step=0 and bounce=0 from the next cycle; restart SHALL still act.
REQ-027 A mode change SHALL apply at the next tick only; no immediate change to leds.

Reset
REQ-028 While rst_n=0: leds = EYE_LEN LSBs set (0x01 at defaults), position 0, direction 0, cnt 0, step 0, bounce 0.
REQ-029 The first tick after rst_n deasserts SHALL occur on the 2^K-th enabled cycle.
REQ-030 Assertion of rst_n mid-sweep SHALL return all state to REQ-028 values without waiting for clk.

Verification (WIDTH=8, PRESCALE_BITS=4, EYE_LEN=1 unless stated)
REQ-031 Bounce, speed=0, enable=1 from reset -> ticks every 16 cycles; leds 0x01,0x02..0x80 by tick 7; tick 8 leaves 0x80 with direction=1 and bounce pulse; tick 9 gives 0x40; tick 16 bounces at 0x01.
REQ-032 EYE_LEN=2, rotate-left -> leds 0x03,0x06..0xC0,0x81,0x03; position 7 shows 0x81; bounce never pulses.
REQ-033 speed=2 -> step every 4 cycles; speed=7 -> K clamps to 1, step every 2 cycles.
REQ-034 enable=0 for 50 cycles mid-sweep at 0x10 -> leds stays 0x10, step stays 0; after re-enable the next tick occurs after the remaining count only.
REQ-035 Rotate-left to position 7 with EYE_LEN=2, then mode=bounce -> next tick gives position 6, leds 0xC0, direction 1, bounce pulse.
REQ-036 restart and tick in the same cycle at leds 0x20 -> leds 0x01, no step; rst_n pulse between clock edges -> leds 0x01 immediately.

Source files
------------

// File: rtl/led_scanner.sv
// led_scanner: Knight-Rider style LED eye. A free-running prescaler produces
// a tick every 2^K enabled cycles; each tick moves an EYE_LEN-wide lit window
// according to the selected mode (bounce, rotate left/right, hold).
module led_scanner #(
   parameter int WIDTH         = 8,
   parameter int PRESCALE_BITS = 18,
   parameter int EYE_LEN       = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [1:0]                 mode,
   input  logic [2:0]                 speed,
   input  logic                       restart,
   output logic [WIDTH-1:0]           leds,
   output logic [$clog2(WIDTH)-1:0]   position,
   output logic                       direction,
   output logic                       step,
   output logic                       bounce
);

   typedef enum logic [1:0] {
      MODE_BOUNCE       = 2'b00,
      MODE_ROTATE_LEFT  = 2'b01,
      MODE_ROTATE_RIGHT = 2'b10,
      MODE_HOLD         = 2'b11
   } mode_e;

   localparam int POS_W = $clog2(WIDTH);
   localparam int MAX_BASE_INT = WIDTH - EYE_LEN;
   localparam logic [POS_W-1:0] MAX_BASE = POS_W'(WIDTH - EYE_LEN);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] RESET_LEDS = {{(WIDTH-EYE_LEN){1'b0}}, {EYE_LEN{1'b1}}};

   logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
   logic [PRESCALE_BITS-1:0] tick_mask;
   logic [POS_W-1:0]         position_q, position_d;
   logic                     direction_q, direction_d;
   logic [WIDTH-1:0]         leds_q, leds_d;
   logic                     step_q, step_d;
   logic                     bounce_q, bounce_d;
   logic                     tick;
   int                       k;

   // Lit window starting at base, wrapping around the top of the LED bar.
   function automatic logic [WIDTH-1:0] eye_at(input logic [POS_W-1:0] base);
      logic [WIDTH-1:0] pattern;
      int offset;
      pattern = '0;
      for (int i = 0; i < WIDTH; i++) begin
         offset = i - int'(base);
         if (offset < 0) offset = offset + WIDTH;
         pattern[i] = (offset < EYE_LEN);
      end
      return pattern;
   endfunction

   // Prescaler: tick when the low K bits are all ones; restart clears it.
   always_comb begin
      k = PRESCALE_BITS - int'(speed);
      if (k < 1) k = 1;
      tick_mask = '0;
      for (int i = 0; i < PRESCALE_BITS; i++) begin
         tick_mask[i] = (i < k);
      end
      tick  = enable && !restart && ((cnt_q & tick_mask) == tick_mask);
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + PRESCALE_BITS'(1);
      end
   end

   // Eye movement on each tick, selected by mode; restart reloads the start pattern.
   always_comb begin
      position_d  = position_q;
      direction_d = direction_q;
      bounce_d    = 1'b0;
      step_d      = tick;
      if (restart) begin
         position_d  = '0;
         direction_d = 1'b0;
      end else if (tick) begin
         case (mode_e'(mode))
            MODE_BOUNCE: begin
               if (int'(position_q) > MAX_BASE_INT) begin
                  position_d  = MAX_BASE;
                  direction_d = 1'b1;
                  bounce_d    = 1'b1;
               end else if (!direction_q) begin
                  if (position_q == MAX_BASE) begin
                     direction_d = 1'b1;
                     bounce_d    = 1'b1;
                  end else begin
                     position_d = position_q + POS_W'(1);
                  end
               end else begin
                  if (position_q == '0) begin
                     direction_d = 1'b0;
                     bounce_d    = 1'b1;
                  end else begin
                     position_d = position_q - POS_W'(1);
                  end
               end
            end
            MODE_ROTATE_LEFT: begin
               position_d  = (position_q == LAST_POS) ? '0 : position_q + POS_W'(1);
               direction_d = 1'b0;
            end
            MODE_ROTATE_RIGHT: begin
               position_d  = (position_q == '0) ? LAST_POS : position_q - POS_W'(1);
               direction_d = 1'b1;
            end
            default: begin
            end
         endcase
      end
      leds_d = eye_at(position_d);
   end

   // State registers; reset returns the eye to the LSB end moving left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         position_q  <= '0;
         direction_q <= 1'b0;
         leds_q      <= RESET_LEDS;
         step_q      <= 1'b0;
         bounce_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         position_q  <= position_d;
         direction_q <= direction_d;
         leds_q      <= leds_d;
         step_q      <= step_d;
         bounce_q    <= bounce_d;
      end
   end

   assign leds      = leds_q;
   assign position  = position_q;
   assign direction = direction_q;
   assign step      = step_q;
   assign bounce    = bounce_q;

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: two scanners (EYE_LEN 1 and 2) driven by shared inputs,
// checked by a scoreboard fed from a behavioural model plus directed checks.
module tb_led_scanner;

   localparam int W  = 8;
   localparam int PB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       restart = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [2:0] speed = 3'd0;

   logic [7:0] leds1, leds2;
   logic [2:0] pos1, pos2;
   logic       dir1, dir2, step1, step2, bnc1, bnc2;

   typedef struct packed {
      logic [7:0] leds;
      logic [2:0] pos;
      logic       dir;
      logic       bnc;
   } rec_t;

   rec_t q1[$];
   rec_t q2[$];

   int checks = 0;
   int errors = 0;

   int         m_cnt = 0;
   int         m_pos[2];
   logic       m_dir[2];
   logic [7:0] m_leds[2];

   led_scanner #(.WIDTH(W), .PRESCALE_BITS(PB), .EYE_LEN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .speed(speed),
      .restart(restart), .leds(leds1), .position(pos1), .direction(dir1),
      .step(step1), .bounce(bnc1)
   );

   led_scanner #(.WIDTH(W), .PRESCALE_BITS(PB), .EYE_LEN(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .speed(speed),
      .restart(restart), .leds(leds2), .position(pos2), .direction(dir2),
      .step(step2), .bounce(bnc2)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Compare one value against its expected value and record the outcome.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive all functional inputs at once.
   task automatic applyStimulus(input logic en, input logic [1:0] md, input logic [2:0] sp, input logic rs);
      enable  = en;
      mode    = md;
      speed   = sp;
      restart = rs;
   endtask

   // Eye pattern from the lit-window rule: bit i lit when (i-pos) mod W < e.
   function automatic logic [7:0] eye_model(input int e, input int p);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < W; i++) begin
         if ((((i - p) % W) + W) % W < e) v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      for (int j = 0; j < 2; j++) begin
         m_pos[j]  = 0;
         m_dir[j]  = 1'b0;
         m_leds[j] = eye_model(j + 1, 0);
      end
   endtask

   // Move one model eye by one tick and queue the response the DUT must show.
   task automatic model_advance(input int j);
      int   e;
      int   maxb;
      logic b;
      rec_t r;
      e    = j + 1;
      maxb = W - e;
      b    = 1'b0;
      case (mode)
         2'b00: begin
            if (m_pos[j] > maxb) begin
               m_pos[j] = maxb; m_dir[j] = 1'b1; b = 1'b1;
            end else if (m_dir[j] == 1'b0) begin
               if (m_pos[j] == maxb) begin m_dir[j] = 1'b1; b = 1'b1; end
               else m_pos[j] = m_pos[j] + 1;
            end else begin
               if (m_pos[j] == 0) begin m_dir[j] = 1'b0; b = 1'b1; end
               else m_pos[j] = m_pos[j] - 1;
            end
         end
         2'b01: begin m_pos[j] = (m_pos[j] + 1) % W; m_dir[j] = 1'b0; end
         2'b10: begin m_pos[j] = (m_pos[j] + W - 1) % W; m_dir[j] = 1'b1; end
         default: begin end
      endcase
      m_leds[j] = eye_model(e, m_pos[j]);
      r.leds = m_leds[j];
      r.pos  = 3'(m_pos[j]);
      r.dir  = m_dir[j];
      r.bnc  = b;
      if (j == 0) q1.push_back(r);
      else        q2.push_back(r);
   endtask

   // Reference model: counts enabled cycles and ticks every 2^K of them.
   initial begin
      int  kk;
      int  period;
      bit  tk;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            kk = PB - int'(speed);
            if (kk < 1) kk = 1;
            period = 1 << kk;
            tk = enable && !restart && ((m_cnt % period) == period - 1);
            if (restart) begin
               model_reset();
            end else if (enable) begin
               m_cnt = (m_cnt + 1) % (1 << PB);
               if (tk) begin
                  model_advance(0);
                  model_advance(1);
               end
            end
         end
      end
   end

   // Scoreboard check for one DUT: a step pops the queued tick response,
   // otherwise the outputs must sit at the model's current state.
   task automatic check_dut(input int j, input logic st, input logic [7:0] l,
                            input logic [2:0] p, input logic d, input logic b);
      rec_t  r;
      int    qs;
      string tag;
      tag = (j == 0) ? "e1" : "e2";
      qs  = (j == 0) ? q1.size() : q2.size();
      if (st) begin
         checkOutput({tag, " step expected"}, 32'(qs > 0), 32'd1);
         if (qs > 0) begin
            if (j == 0) r = q1.pop_front();
            else        r = q2.pop_front();
            checkOutput({tag, " step leds"}, 32'(l), 32'(r.leds));
            checkOutput({tag, " step position"}, 32'(p), 32'(r.pos));
            checkOutput({tag, " step direction"}, 32'(d), 32'(r.dir));
            checkOutput({tag, " step bounce"}, 32'(b), 32'(r.bnc));
         end
      end else begin
         checkOutput({tag, " step missing"}, 32'(qs), 32'd0);
         if (qs > 0) begin
            if (j == 0) r = q1.pop_front();
            else        r = q2.pop_front();
         end
         checkOutput({tag, " idle leds"}, 32'(l), 32'(m_leds[j]));
         checkOutput({tag, " idle position"}, 32'(p), 32'(m_pos[j]));
         checkOutput({tag, " idle direction"}, 32'(d), 32'(m_dir[j]));
         checkOutput({tag, " idle bounce"}, 32'(b), 32'd0);
      end
   endtask

   // Monitor: samples both DUTs on the falling edge, away from updates.
   initial begin
      forever begin
         @(negedge clk);
         check_dut(0, step1, leds1, pos1, dir1, bnc1);
         check_dut(1, step2, leds2, pos2, dir2, bnc2);
      end
   end

   // Advance until n steps are seen on the first DUT, bounded by a cycle budget.
   task automatic wait_steps(input int n, input int budget, output int cyc);
      int seen;
      seen = 0;
      cyc  = 0;
      while (seen < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (step1) seen++;
      end
      if (seen < n) checkOutput("step wait timeout", 32'(seen), 32'(n));
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then a randomized soak.
   initial begin
      int cyc;
      int steps;
      applyStimulus(1'b1, 2'b00, 3'd0, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset leds e1", 32'(leds1), 32'h01);
      checkOutput("reset leds e2", 32'(leds2), 32'h03);
      checkOutput("reset position", 32'(pos1), 32'd0);
      checkOutput("reset direction", 32'(dir1), 32'd0);
      checkOutput("reset step", 32'(step1), 32'd0);
      checkOutput("reset bounce", 32'(bnc1), 32'd0);

      // Bounce sweep at speed 0: tick every 16 cycles.
      rst_n = 1'b1;
      wait_steps(1, 40, cyc);
      checkOutput("first tick latency", 32'(cyc), 32'd16);
      wait_steps(6, 200, cyc);
      checkOutput("tick7 leds", 32'(leds1), 32'h80);
      wait_steps(1, 40, cyc);
      checkOutput("tick8 leds", 32'(leds1), 32'h80);
      checkOutput("tick8 direction", 32'(dir1), 32'd1);
      checkOutput("tick8 bounce", 32'(bnc1), 32'd1);
      wait_steps(1, 40, cyc);
      checkOutput("tick9 leds", 32'(leds1), 32'h40);
      wait_steps(7, 200, cyc);
      checkOutput("tick16 leds", 32'(leds1), 32'h01);
      checkOutput("tick16 bounce", 32'(bnc1), 32'd1);

      // Step rate versus speed.
      applyStimulus(1'b1, 2'b00, 3'd2, 1'b0);
      wait_steps(1, 40, cyc);
      wait_steps(1, 40, cyc);
      checkOutput("speed2 interval", 32'(cyc), 32'd4);
      applyStimulus(1'b1, 2'b00, 3'd7, 1'b0);
      wait_steps(1, 40, cyc);
      wait_steps(1, 40, cyc);
      checkOutput("speed7 interval", 32'(cyc), 32'd2);

      // Freeze mid-sweep, then resume with the remaining count.
      applyStimulus(1'b1, 2'b00, 3'd0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 2'b00, 3'd0, 1'b0);
      wait_steps(4, 100, cyc);
      checkOutput("pre-freeze leds", 32'(leds1), 32'h10);
      repeat (5) @(negedge clk);
      applyStimulus(1'b0, 2'b00, 3'd0, 1'b0);
      steps = 0;
      repeat (50) begin
         @(negedge clk);
         if (step1) steps++;
      end
      checkOutput("frozen leds", 32'(leds1), 32'h10);
      checkOutput("frozen steps", 32'(steps), 32'd0);
      applyStimulus(1'b1, 2'b00, 3'd0, 1'b0);
      wait_steps(1, 40, cyc);
      checkOutput("resume remaining count", 32'(cyc), 32'd11);
      checkOutput("resume leds", 32'(leds1), 32'h20);

      // Restart in the same cycle as a tick.
      repeat (15) @(negedge clk);
      applyStimulus(1'b1, 2'b00, 3'd0, 1'b1);
      @(negedge clk);
      checkOutput("restart leds", 32'(leds1), 32'h01);
      checkOutput("restart step", 32'(step1), 32'd0);
      applyStimulus(1'b1, 2'b00, 3'd0, 1'b0);

      // Asynchronous reset between clock edges.
      wait_steps(2, 40, cyc);
      checkOutput("pre-reset leds", 32'(leds1), 32'h04);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset leds e1", 32'(leds1), 32'h01);
      checkOutput("async reset leds e2", 32'(leds2), 32'h03);
      checkOutput("async reset position", 32'(pos1), 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Rotate-left with a two-LED eye, then switch to bounce from position 7.
      applyStimulus(1'b1, 2'b01, 3'd3, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 3'd3, 1'b0);
      checkOutput("rotl start leds", 32'(leds2), 32'h03);
      wait_steps(1, 10, cyc);
      checkOutput("rotl tick1 leds", 32'(leds2), 32'h06);
      wait_steps(6, 40, cyc);
      checkOutput("rotl wrap leds", 32'(leds2), 32'h81);
      checkOutput("rotl wrap position", 32'(pos2), 32'd7);
      applyStimulus(1'b1, 2'b00, 3'd3, 1'b0);
      wait_steps(1, 10, cyc);
      checkOutput("reenter position", 32'(pos2), 32'd6);
      checkOutput("reenter leds", 32'(leds2), 32'hC0);
      checkOutput("reenter direction", 32'(dir2), 32'd1);
      checkOutput("reenter bounce", 32'(bnc2), 32'd1);

      // Randomized soak; the monitor checks everything against the model.
      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 2) speed = 3'($urandom_range(0, 7));
         enable  = ($urandom_range(0, 9) != 0);
         restart = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end
      applyStimulus(1'b1, 2'b00, 3'd0, 1'b0);
      @(negedge clk);
      checkOutput("e1 queue drained", 32'(q1.size()), 32'd0);
      checkOutput("e2 queue drained", 32'(q2.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
